cam_cmd_ctrl: RTL and testbench

Command sequencer that sits directly upstream of the 32-entry CAM and drives its write, read and search ports. It accepts one READ, WRITE or SEARCH command at a time over a valid/ready handshake and issues single-cycle CAM strobes. It samples the CAM results after a fixed latency and returns a response over a valid/ready handshake. It keeps one command outstanding, so there are no read-after-write or search-after-write hazards.

---
 rtl/cam_cmd_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_cam_cmd_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_cmd_ctrl.sv
// cam_cmd_ctrl: single-outstanding command sequencer in front of a CAM (write/read/search ports).
// Define CAM_CMD_CTRL_STATS_EN to add saturating SEARCH hit/miss counters.
module cam_cmd_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned CAM_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [INDEX_W-1:0] cmd_index_i,
  input  logic [DATA_W-1:0]  cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [1:0]         rsp_op_o,
  output logic               rsp_hit_o,
  output logic               rsp_err_o,
  output logic [INDEX_W-1:0] rsp_index_o,
  output logic [DATA_W-1:0]  rsp_data_o,
  output logic               cam_write_enable_o,
  output logic [INDEX_W-1:0] cam_write_index_o,
  output logic [DATA_W-1:0]  cam_write_data_o,
  output logic [INDEX_W-1:0] cam_read_index_o,
  input  logic [DATA_W-1:0]  cam_read_value_i,
  input  logic               cam_read_valid_i,
  output logic               cam_search_enable_o,
  output logic [DATA_W-1:0]  cam_search_data_o,
  input  logic [INDEX_W-1:0] cam_search_index_i,
`ifdef CAM_CMD_CTRL_STATS_EN
  output logic [CNT_W-1:0]   stat_hit_cnt_o,
  output logic [CNT_W-1:0]   stat_miss_cnt_o,
`endif
  input  logic               cam_search_valid_i
);

  if (CAM_LAT < 1 || CAM_LAT > 4 || CNT_W < 1) begin : g_param_check
    $error("cam_cmd_ctrl: CAM_LAT must be 1..4 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_SEARCH, OP_ILLEGAL} op_e;

  state_e               state_q, state_d;
  logic                 live_q, live_d;
  logic [1:0]           op_q, op_d;
  logic [INDEX_W-1:0]   index_q, index_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [2:0]           wait_cnt_q, wait_cnt_d;
  logic [1:0]           rsp_op_q, rsp_op_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [INDEX_W-1:0]   rsp_index_q, rsp_index_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
`ifdef CAM_CMD_CTRL_STATS_EN
  logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;
`endif

  // live_q keeps cmd_ready_o low while in reset and for the release cycle
  assign cmd_ready_o         = live_q && (state_q == IDLE);
  assign rsp_valid_o         = (state_q == RESP);
  assign cam_write_enable_o  = (state_q == ISSUE) && (op_q == OP_WRITE);
  assign cam_search_enable_o = (state_q == ISSUE) && (op_q == OP_SEARCH);
  assign cam_write_index_o   = index_q;
  assign cam_write_data_o    = data_q;
  assign cam_read_index_o    = index_q;
  assign cam_search_data_o   = data_q;
  assign rsp_op_o            = rsp_op_q;
  assign rsp_hit_o           = rsp_hit_q;
  assign rsp_err_o           = rsp_err_q;
  assign rsp_index_o         = rsp_index_q;
  assign rsp_data_o          = rsp_data_q;
`ifdef CAM_CMD_CTRL_STATS_EN
  assign stat_hit_cnt_o      = hit_cnt_q;
  assign stat_miss_cnt_o     = miss_cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    live_d      = 1'b1;
    op_d        = op_q;
    index_d     = index_q;
    data_d      = data_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_op_d    = rsp_op_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_err_d   = rsp_err_q;
    rsp_index_d = rsp_index_q;
    rsp_data_d  = rsp_data_q;
`ifdef CAM_CMD_CTRL_STATS_EN
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          op_d    = cmd_op_i;
          index_d = cmd_index_i;
          data_d  = cmd_data_i;
          if (cmd_op_i == OP_ILLEGAL) begin
            state_d     = RESP;
            rsp_op_d    = cmd_op_i;
            rsp_hit_d   = 1'b0;
            rsp_err_d   = 1'b1;
            rsp_index_d = '0;
            rsp_data_d  = '0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == 3'(CAM_LAT - 1)) begin
          state_d     = RESP;
          rsp_op_d    = op_q;
          rsp_err_d   = 1'b0;
          rsp_hit_d   = 1'b0;
          rsp_index_d = index_q;
          rsp_data_d  = data_q;
          if (op_q == OP_READ) begin
            rsp_hit_d  = cam_read_valid_i;
            rsp_data_d = cam_read_value_i;
          end else if (op_q == OP_SEARCH) begin
            rsp_hit_d   = cam_search_valid_i;
            rsp_index_d = cam_search_valid_i ? cam_search_index_i : '0;
`ifdef CAM_CMD_CTRL_STATS_EN
            if (cam_search_valid_i) begin
              if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end else begin
              if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            end
`endif
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      live_q      <= 1'b0;
      op_q        <= '0;
      index_q     <= '0;
      data_q      <= '0;
      wait_cnt_q  <= '0;
      rsp_op_q    <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_data_q  <= '0;
`ifdef CAM_CMD_CTRL_STATS_EN
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      live_q      <= live_d;
      op_q        <= op_d;
      index_q     <= index_d;
      data_q      <= data_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_op_q    <= rsp_op_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_err_q   <= rsp_err_d;
      rsp_index_q <= rsp_index_d;
      rsp_data_q  <= rsp_data_d;
`ifdef CAM_CMD_CTRL_STATS_EN
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_cam_cmd_ctrl.sv
// Bench for cam_cmd_ctrl: behavioural CAM, reference-model scoreboard, per-scenario tasks.
// Mirrors CAM_CMD_CTRL_STATS_EN to check the optional counters.
module tb_cam_cmd_ctrl;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned INDEX_W = 5;
  localparam int unsigned CAM_LAT = 1;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned ROWS    = 1 << INDEX_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [INDEX_W-1:0] cmd_index = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [1:0] rsp_op;
  logic rsp_hit, rsp_err;
  logic [INDEX_W-1:0] rsp_index;
  logic [DATA_W-1:0] rsp_data;
  logic cam_we, cam_se;
  logic [INDEX_W-1:0] cam_wi, cam_ri, cam_si;
  logic [DATA_W-1:0] cam_wd, cam_rv, cam_sd;
  logic cam_rvld, cam_svld;
`ifdef CAM_CMD_CTRL_STATS_EN
  logic [CNT_W-1:0] hit_cnt, miss_cnt;
`endif

  cam_cmd_ctrl #(.DATA_W(DATA_W), .INDEX_W(INDEX_W), .CAM_LAT(CAM_LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_index_i(cmd_index), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_op_o(rsp_op),
    .rsp_hit_o(rsp_hit), .rsp_err_o(rsp_err), .rsp_index_o(rsp_index), .rsp_data_o(rsp_data),
    .cam_write_enable_o(cam_we), .cam_write_index_o(cam_wi), .cam_write_data_o(cam_wd),
    .cam_read_index_o(cam_ri), .cam_read_value_i(cam_rv), .cam_read_valid_i(cam_rvld),
    .cam_search_enable_o(cam_se), .cam_search_data_o(cam_sd),
    .cam_search_index_i(cam_si),
`ifdef CAM_CMD_CTRL_STATS_EN
    .stat_hit_cnt_o(hit_cnt), .stat_miss_cnt_o(miss_cnt),
`endif
    .cam_search_valid_i(cam_svld)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]         op;
    logic               hit;
    logic               err;
    logic [INDEX_W-1:0] index;
    logic [DATA_W-1:0]  data;
  } rsp_t;
  typedef struct { rsp_t r; int unsigned cyc; } exp_t;

  exp_t exp_q[$];
  int unsigned total = 0, bad = 0;
  int unsigned cyc = 0, wr_cnt = 0, sr_cnt = 0, first_cyc = 0;
  logic prev_valid = 1'b0;

  // behavioural CAM: registered write and search, asynchronous read
  logic [DATA_W-1:0] cam_mem [ROWS];
  logic              cam_vld [ROWS];
  logic [DATA_W-1:0] ref_mem [ROWS];
  logic              ref_vld [ROWS];
  logic [INDEX_W-1:0] cam_si_q = '0;
  logic               cam_svld_q = 1'b0;

  initial begin
    for (int i = 0; i < ROWS; i++) begin
      cam_mem[i] = '0; cam_vld[i] = 1'b0; ref_mem[i] = '0; ref_vld[i] = 1'b0;
    end
  end

  assign cam_rv   = cam_mem[cam_ri];
  assign cam_rvld = cam_vld[cam_ri];
  assign cam_si   = cam_si_q;
  assign cam_svld = cam_svld_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cam_we) begin
      cam_mem[cam_wi] <= cam_wd;
      cam_vld[cam_wi] <= 1'b1;
    end
    if (cam_se) begin
      cam_svld_q <= 1'b0;
      cam_si_q   <= '0;
      for (int i = ROWS - 1; i >= 0; i--)
        if (cam_vld[i] && cam_mem[i] == cam_sd) begin
          cam_svld_q <= 1'b1;
          cam_si_q   <= INDEX_W'(i);
        end
    end
  end

  // scoreboard: pops one expectation per response handshake
  always @(negedge clk) begin
    rsp_t obs;
    exp_t e;
    #2;
    if (cam_we) wr_cnt++;
    if (cam_se) sr_cnt++;
    if (rsp_valid && !prev_valid) first_cyc = cyc;
    prev_valid = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      obs = {rsp_op, rsp_hit, rsp_err, rsp_index, rsp_data};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: got %h at cycle %0d, required no response", obs, cyc);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e.r || first_cyc != e.cyc) begin
          bad++;
          $display("FAIL rsp: got %h at cycle %0d, required %h at cycle %0d", obs, first_cyc, e.r, e.cyc);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [INDEX_W-1:0] idx,
                      input logic [DATA_W-1:0] data, input bit push);
    exp_t e;
    int n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL send_ready: cmd_ready=%b, required 1 within 50 cycles", cmd_ready);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_index = idx; cmd_data = data;
    if (push) begin
      e.r = '0;
      e.r.op = op;
      e.cyc = cyc + 2 + CAM_LAT;
      case (op)
        2'b00: begin
          e.r.hit = ref_vld[idx]; e.r.index = idx; e.r.data = ref_mem[idx];
        end
        2'b01: begin
          e.r.index = idx; e.r.data = data;
          ref_mem[idx] = data; ref_vld[idx] = 1'b1;
        end
        2'b10: begin
          e.r.data = data;
          for (int i = 0; i < ROWS; i++)
            if (!e.r.hit && ref_vld[i] && ref_mem[i] == data) begin
              e.r.hit = 1'b1; e.r.index = INDEX_W'(i);
            end
        end
        default: begin
          e.r.err = 1'b1; e.cyc = cyc + 1;
        end
      endcase
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [127:0] outs;
    repeat (2) @(negedge clk);
    outs = {cmd_ready, rsp_valid, rsp_op, rsp_hit, rsp_err, rsp_index, rsp_data,
            cam_we, cam_se, cam_wi, cam_ri, cam_wd, cam_sd};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_outs: got %h, required 0", outs); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b, required 1", cmd_ready); end
  endtask

  task automatic test_write();
    int unsigned w0 = wr_cnt;
    send(2'b01, 5, 32'hDEADBEEF, 1);
    total++;
    if ({cam_we, cam_wi, cam_wd} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      bad++; $display("FAIL write_strobe: got %b/%0d/%h, required 1/5/deadbeef", cam_we, cam_wi, cam_wd);
    end
    @(negedge clk);
    total++;
    if (cam_we !== 1'b0) begin bad++; $display("FAIL write_strobe_width: got %b, required 0", cam_we); end
    wait_done();
    total++;
    if (wr_cnt - w0 != 1) begin bad++; $display("FAIL write_count: got %0d, required 1", wr_cnt - w0); end
  endtask

  task automatic test_read();
    send(2'b00, 5, '0, 1);
    wait_done();
    send(2'b00, 6, '0, 1);
    wait_done();
  endtask

  task automatic test_search();
    int unsigned s0 = sr_cnt;
    send(2'b01, 3, 32'h1234, 1); wait_done();
    send(2'b01, 9, 32'h1234, 1); wait_done();
    send(2'b10, 0, 32'h1234, 1); wait_done();
    send(2'b10, 0, 32'h5555, 1); wait_done();
    send(2'b10, 0, 32'hDEADBEEF, 1); wait_done();
    total++;
    if (sr_cnt - s0 != 3) begin bad++; $display("FAIL search_count: got %0d, required 3", sr_cnt - s0); end
`ifdef CAM_CMD_CTRL_STATS_EN
    total++;
    if (hit_cnt !== 16'd2 || miss_cnt !== 16'd1) begin
      bad++; $display("FAIL stats: got hit=%0d miss=%0d, required hit=2 miss=1", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_illegal();
    int unsigned w0 = wr_cnt, s0 = sr_cnt;
    send(2'b11, 7, 32'hAAAA5555, 1);
    total++;
    if ({rsp_valid, rsp_err} !== 2'b11) begin
      bad++; $display("FAIL illegal_latency: got valid=%b err=%b, required 1 1", rsp_valid, rsp_err);
    end
    wait_done();
    total++;
    if (wr_cnt != w0 || sr_cnt != s0) begin
      bad++; $display("FAIL illegal_strobe: got %0d strobes, required 0", (wr_cnt - w0) + (sr_cnt - s0));
    end
  endtask

  task automatic test_backpressure();
    rsp_t snap, now;
    int n = 0;
    int unsigned w0;
    rsp_ready = 1'b0;
    send(2'b00, 5, '0, 1);
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    snap = {rsp_op, rsp_hit, rsp_err, rsp_index, rsp_data};
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i == 2); cmd_op = 2'b01; cmd_index = 1; cmd_data = 32'h77;
      @(negedge clk);
      now = {rsp_op, rsp_hit, rsp_err, rsp_index, rsp_data};
      total++;
      if (!rsp_valid || now !== snap || cmd_ready !== 1'b0) begin
        bad++; $display("FAIL backpressure: got valid=%b ready=%b rsp=%h, required 1 0 %h",
                        rsp_valid, cmd_ready, now, snap);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_done();
    repeat (4) @(negedge clk);
    total++;
    if (wr_cnt != w0) begin bad++; $display("FAIL backpressure_ignore: got %0d writes, required 0", wr_cnt - w0); end
  endtask

  task automatic test_reset_midop();
    send(2'b01, 7, 32'hCAFEF00D, 0);
    total++;
    if (cam_we !== 1'b1) begin bad++; $display("FAIL midop_issue: got %b, required 1", cam_we); end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({cam_we, rsp_valid, cmd_ready} !== 3'b000) begin
      bad++; $display("FAIL midop_async: got we/valid/ready=%b, required 000", {cam_we, rsp_valid, cmd_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midop_ready: got %b, required 1", cmd_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midop_norsp: got %b, required 0", rsp_valid); end
    end
    total++;
    if (cam_vld[7] !== 1'b0) begin bad++; $display("FAIL midop_nowrite: got %b, required 0", cam_vld[7]); end
`ifdef CAM_CMD_CTRL_STATS_EN
    total++;
    if (hit_cnt !== '0 || miss_cnt !== '0) begin
      bad++; $display("FAIL stats_reset: got hit=%0d miss=%0d, required 0 0", hit_cnt, miss_cnt);
    end
`endif
    send(2'b00, 7, '0, 1);
    wait_done();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_search();
    test_illegal();
    test_backpressure();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
